// File: rtl/noc_link_pkg.sv
// Shared NoC link types: flit layout, wormhole packet state and credit sizing.
// Used by both the flit transmitter and the receive-side credit logic.
package noc_link_pkg;

  localparam int FLIT_DATA_W = 64;
  localparam int FLIT_DEST_W = 4;

  typedef struct packed {
    logic [FLIT_DATA_W-1:0] data;
    logic [FLIT_DEST_W-1:0] dest;
    logic                   is_tail;
  } flit_t;

  typedef enum logic {
    HEAD = 1'b0,
    BODY = 1'b1
  } pkt_state_t;

  // Counter must hold every value from 0 up to and including the buffer depth.
  function automatic int credit_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/noc_credit_counter.sv
// Up/down credit counter saturating at 0 and MAX_COUNT; next-cycle update, never stalls.
// An increment while already at MAX_COUNT is dropped and sets the sticky ovf flag.
module noc_credit_counter #(
  parameter int MAX_COUNT   = 4,
  parameter int WIDTH       = 3,
  parameter int RESET_COUNT = MAX_COUNT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] RST_C = WIDTH'(RESET_COUNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= RST_C;
      ovf   <= 1'b0;
    end else if (inc && !dec) begin
      if (count == MAX_C) ovf <= 1'b1;
      else                count <= count + 1'b1;
    end else if (dec && !inc && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/axis_credit_flit_tx.sv
// AXI-Stream to credit-based flit link; one registered flit per accepted beat, 1-cycle latency.
// tready is high whenever a credit is held and depends only on registered state.
module axis_credit_flit_tx
  import noc_link_pkg::*;
#(
  parameter int TDATA_WIDTH       = 64,
  parameter int TDEST_WIDTH       = 2,
  parameter int TID_WIDTH         = 2,
  parameter int DEST_WIDTH        = TDEST_WIDTH + TID_WIDTH,
  parameter int FLIT_BUFFER_DEPTH = 4,
  parameter int CREDIT_WIDTH      = credit_width(FLIT_BUFFER_DEPTH)
) (
  input  logic                    clk_noc,
  input  logic                    rst_noc,
  input  logic                    axis_in_tvalid,
  output logic                    axis_in_tready,
  input  logic [TDATA_WIDTH-1:0]  axis_in_tdata,
  input  logic                    axis_in_tlast,
  input  logic [TID_WIDTH-1:0]    axis_in_tid,
  input  logic [TDEST_WIDTH-1:0]  axis_in_tdest,
  output logic [TDATA_WIDTH-1:0]  data_out,
  output logic [DEST_WIDTH-1:0]   dest_out,
  output logic                    is_tail_out,
  output logic                    send_out,
  input  logic                    credit_in,
  output logic [CREDIT_WIDTH-1:0] credits_avail,
  output logic                    pkt_active,
  output logic                    err_credit_ovf
);

  typedef struct packed {
    logic [TDATA_WIDTH-1:0] data;
    logic [DEST_WIDTH-1:0]  dest;
    logic                   is_tail;
  } link_flit_t;

  pkt_state_t             state;
  link_flit_t             flit_q;
  logic [DEST_WIDTH-1:0]  head_dest;
  logic [DEST_WIDTH-1:0]  beat_dest;
  logic                   fire;

  assign axis_in_tready = (credits_avail != '0);
  assign fire           = axis_in_tvalid && axis_in_tready;
  assign beat_dest      = {axis_in_tid, axis_in_tdest};

  noc_credit_counter #(
    .MAX_COUNT   (FLIT_BUFFER_DEPTH),
    .WIDTH       (CREDIT_WIDTH),
    .RESET_COUNT (FLIT_BUFFER_DEPTH)
  ) u_credits (
    .clk   (clk_noc),
    .rst   (rst_noc),
    .inc   (credit_in),
    .dec   (fire),
    .count (credits_avail),
    .ovf   (err_credit_ovf)
  );

  // Wormhole tracking: only the head beat's tid/tdest routes the packet.
  always_ff @(posedge clk_noc or posedge rst_noc) begin
    if (rst_noc) begin
      state     <= HEAD;
      head_dest <= '0;
      flit_q    <= '0;
      send_out  <= 1'b0;
    end else begin
      send_out <= fire;
      if (fire) begin
        flit_q.data    <= axis_in_tdata;
        flit_q.is_tail <= axis_in_tlast;
        unique case (state)
          HEAD: begin
            flit_q.dest <= beat_dest;
            if (!axis_in_tlast) begin
              head_dest <= beat_dest;
              state     <= BODY;
            end
          end
          BODY: begin
            flit_q.dest <= head_dest;
            if (axis_in_tlast) state <= HEAD;
          end
          default: state <= HEAD;
        endcase
      end
    end
  end

  assign data_out    = flit_q.data;
  assign dest_out    = flit_q.dest;
  assign is_tail_out = flit_q.is_tail;
  assign pkt_active  = (state == BODY);

endmodule

// File: tb/tb_axis_credit_flit_tx.sv
// Scoreboard bench for axis_credit_flit_tx: expected flits queued at drive time, checked on send_out.
module tb_axis_credit_flit_tx;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [63:0] data;
    logic [3:0]  dest;
    logic        tail;
  } exp_t;

  logic        clk_noc = 1'b0;
  logic        rst_noc;
  logic        axis_in_tvalid;
  logic        axis_in_tready;
  logic [63:0] axis_in_tdata;
  logic        axis_in_tlast;
  logic [1:0]  axis_in_tid;
  logic [1:0]  axis_in_tdest;
  logic [63:0] data_out;
  logic [3:0]  dest_out;
  logic        is_tail_out;
  logic        send_out;
  logic        credit_in;
  logic [2:0]  credits_avail;
  logic        pkt_active;
  logic        err_credit_ovf;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  // Reference model state
  int         m_credits;
  logic       m_ovf;
  logic       m_body;
  logic [3:0] m_dest;
  logic       fire_pending;
  logic       mon_en;

  axis_credit_flit_tx #(
    .TDATA_WIDTH(64), .TDEST_WIDTH(2), .TID_WIDTH(2), .DEST_WIDTH(4),
    .FLIT_BUFFER_DEPTH(DEPTH), .CREDIT_WIDTH(3)
  ) dut (
    .clk_noc(clk_noc), .rst_noc(rst_noc),
    .axis_in_tvalid(axis_in_tvalid), .axis_in_tready(axis_in_tready),
    .axis_in_tdata(axis_in_tdata), .axis_in_tlast(axis_in_tlast),
    .axis_in_tid(axis_in_tid), .axis_in_tdest(axis_in_tdest),
    .data_out(data_out), .dest_out(dest_out), .is_tail_out(is_tail_out),
    .send_out(send_out), .credit_in(credit_in), .credits_avail(credits_avail),
    .pkt_active(pkt_active), .err_credit_ovf(err_credit_ovf)
  );

  always #5 clk_noc = ~clk_noc;

  // Output monitor: sampled 1 time unit after each rising edge.
  always @(posedge clk_noc) begin
    exp_t e;
    #1;
    if (mon_en) begin
      checks++;
      if (send_out !== fire_pending) begin
        failures++;
        $display("FAIL send_pulse: send_out=%b expected=%b at %0t", send_out, fire_pending, $time);
      end
      if (send_out === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL flit_unexpected: flit data=%h with empty scoreboard", data_out);
        end else begin
          e = sb.pop_front();
          if ({data_out, dest_out, is_tail_out} !== e) begin
            failures++;
            $display("FAIL flit_content: got data=%h dest=%b tail=%b expected data=%h dest=%b tail=%b",
                     data_out, dest_out, is_tail_out, e.data, e.dest, e.tail);
          end
        end
      end
    end
  end

  // Drive one cycle of stimulus from a falling edge; returns at the next falling edge.
  task automatic drive(input logic v, input logic [63:0] d, input logic last,
                       input logic [1:0] id, input logic [1:0] dst, input logic cr);
    logic fire;
    exp_t e;
    axis_in_tvalid = v;
    axis_in_tdata  = d;
    axis_in_tlast  = last;
    axis_in_tid    = id;
    axis_in_tdest  = dst;
    credit_in      = cr;
    fire = v && (m_credits != 0);
    if (fire) begin
      e.data = d;
      e.tail = last;
      if (!m_body) begin
        e.dest = {id, dst};
        if (!last) begin
          m_dest = {id, dst};
          m_body = 1'b1;
        end
      end else begin
        e.dest = m_dest;
        if (last) m_body = 1'b0;
      end
      sb.push_back(e);
    end
    if (fire && !cr) m_credits--;
    else if (!fire && cr) begin
      if (m_credits == DEPTH) m_ovf = 1'b1;
      else m_credits++;
    end
    fire_pending = fire;
    @(negedge clk_noc);
  endtask

  task automatic idle(input logic cr);
    drive(1'b0, 64'd0, 1'b0, 2'd0, 2'd0, cr);
  endtask

  task automatic refill();
    while (m_credits < DEPTH) idle(1'b1);
    idle(1'b0);
  endtask

  task automatic apply_reset();
    mon_en         = 1'b0;
    fire_pending   = 1'b0;
    axis_in_tvalid = 1'b0;
    credit_in      = 1'b0;
    rst_noc        = 1'b1;
    @(negedge clk_noc);
    rst_noc   = 1'b0;
    sb.delete();
    m_credits = DEPTH;
    m_ovf     = 1'b0;
    m_body    = 1'b0;
    m_dest    = 4'd0;
    mon_en    = 1'b1;
  endtask

  task automatic test_reset();
    rst_noc = 1'b1;
    #1;
    checks++;
    if ({send_out, data_out, dest_out, is_tail_out, pkt_active, err_credit_ovf} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: send=%b data=%h dest=%b tail=%b active=%b ovf=%b expected all zero",
               send_out, data_out, dest_out, is_tail_out, pkt_active, err_credit_ovf);
    end
    checks++;
    if (credits_avail !== 3'(DEPTH) || axis_in_tready !== 1'b1) begin
      failures++;
      $display("FAIL reset_credits: credits=%0d tready=%b expected credits=%0d tready=1",
               credits_avail, axis_in_tready, DEPTH);
    end
    @(negedge clk_noc);
    apply_reset();
  endtask

  task automatic test_single_flit();
    drive(1'b1, 64'hA5, 1'b1, 2'd1, 2'd2, 1'b0);
    checks++;
    if (credits_avail !== 3'd3 || dest_out !== 4'b0110) begin
      failures++;
      $display("FAIL single_flit: credits=%0d dest=%b expected credits=3 dest=0110", credits_avail, dest_out);
    end
    idle(1'b1);
    checks++;
    if (send_out !== 1'b0 || data_out !== 64'hA5 || is_tail_out !== 1'b1) begin
      failures++;
      $display("FAIL hold_outputs: send=%b data=%h tail=%b expected send=0 data=a5 tail=1",
               send_out, data_out, is_tail_out);
    end
  endtask

  task automatic test_credit_exhaust();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 64'h1000 + 64'(i), (i == 3), 2'd1, 2'd1, 1'b0);
      checks++;
      if (axis_in_tready !== (m_credits != 0) || credits_avail !== 3'(m_credits)) begin
        failures++;
        $display("FAIL exhaust_step%0d: credits=%0d tready=%b expected credits=%0d",
                 i, credits_avail, axis_in_tready, m_credits);
      end
    end
    checks++;
    if (credits_avail !== 3'd0 || axis_in_tready !== 1'b0) begin
      failures++;
      $display("FAIL exhaust_empty: credits=%0d tready=%b expected 0/0", credits_avail, axis_in_tready);
    end
    drive(1'b1, 64'hDEAD, 1'b1, 2'd0, 2'd0, 1'b0);
    idle(1'b1);
    checks++;
    if (credits_avail !== 3'd1 || axis_in_tready !== 1'b1) begin
      failures++;
      $display("FAIL credit_return: credits=%0d tready=%b expected 1/1", credits_avail, axis_in_tready);
    end
    refill();
  endtask

  task automatic test_body_dest();
    drive(1'b1, {$urandom, $urandom}, 1'b0, 2'd2, 2'd1, 1'b0);
    checks++;
    if (pkt_active !== 1'b1) begin
      failures++;
      $display("FAIL active_after_head: pkt_active=%b expected 1", pkt_active);
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, {$urandom, $urandom}, 1'b0, 2'd3, 2'd3, 1'b0);
      checks++;
      if (pkt_active !== 1'b1 || dest_out !== 4'b1001) begin
        failures++;
        $display("FAIL body_dest%0d: pkt_active=%b dest=%b expected 1/1001", i, pkt_active, dest_out);
      end
    end
    drive(1'b1, {$urandom, $urandom}, 1'b1, 2'd3, 2'd3, 1'b1);
    checks++;
    if (pkt_active !== 1'b0 || dest_out !== 4'b1001) begin
      failures++;
      $display("FAIL tail_dest: pkt_active=%b dest=%b expected 0/1001", pkt_active, dest_out);
    end
    refill();
  endtask

  task automatic test_back_to_back();
    logic [1:0] hist;
    drive(1'b1, 64'h11, 1'b1, 2'd0, 2'd1, 1'b0);
    drive(1'b1, 64'h22, 1'b1, 2'd0, 2'd2, 1'b0);
    drive(1'b1, 64'h33, 1'b1, 2'd0, 2'd3, 1'b1);
    checks++;
    if (credits_avail !== 3'd2) begin
      failures++;
      $display("FAIL fire_and_credit: credits=%0d expected 2", credits_avail);
    end
    refill();
    hist = 2'b00;
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (axis_in_tready !== 1'b1) begin
        failures++;
        $display("FAIL sustained_ready%0d: tready=%b credits=%0d expected tready=1", i, axis_in_tready, credits_avail);
      end
      drive(1'b1, 64'h5000 + 64'(i), 1'b1, 2'(i), 2'(i + 1), hist[1]);
      hist = {hist[0], 1'b1};
    end
    checks++;
    if (credits_avail !== 3'd2) begin
      failures++;
      $display("FAIL sustained_credits: credits=%0d expected 2", credits_avail);
    end
    idle(hist[1]);
    idle(hist[0]);
    refill();
  endtask

  task automatic test_credit_ovf();
    apply_reset();
    idle(1'b1);
    checks++;
    if (credits_avail !== 3'(DEPTH) || err_credit_ovf !== 1'b1) begin
      failures++;
      $display("FAIL ovf_set: credits=%0d ovf=%b expected %0d/1", credits_avail, err_credit_ovf, DEPTH);
    end
    drive(1'b1, 64'h77, 1'b1, 2'd2, 2'd2, 1'b0);
    idle(1'b1);
    checks++;
    if (err_credit_ovf !== m_ovf || credits_avail !== 3'(m_credits)) begin
      failures++;
      $display("FAIL ovf_sticky: ovf=%b credits=%0d expected 1/%0d", err_credit_ovf, credits_avail, m_credits);
    end
  endtask

  task automatic test_reset_mid_packet();
    drive(1'b1, 64'hA1, 1'b0, 2'd1, 2'd3, 1'b0);
    drive(1'b1, 64'hA2, 1'b0, 2'd1, 2'd3, 1'b0);
    drive(1'b1, 64'hA3, 1'b0, 2'd1, 2'd3, 1'b0);
    checks++;
    if (credits_avail !== 3'd1 || pkt_active !== 1'b1 || send_out !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset: credits=%0d active=%b send=%b expected 1/1/1", credits_avail, pkt_active, send_out);
    end
    mon_en = 1'b0;
    axis_in_tvalid = 1'b0;
    #2 rst_noc = 1'b1;
    #1;
    checks++;
    if ({send_out, data_out, dest_out, is_tail_out, pkt_active, err_credit_ovf} !== '0 ||
        credits_avail !== 3'(DEPTH) || axis_in_tready !== 1'b1) begin
      failures++;
      $display("FAIL async_reset: send=%b data=%h dest=%b active=%b ovf=%b credits=%0d expected reset values",
               send_out, data_out, dest_out, pkt_active, err_credit_ovf, credits_avail);
    end
    @(negedge clk_noc);
    apply_reset();
    drive(1'b1, 64'hB0, 1'b0, 2'd0, 2'd3, 1'b0);
    checks++;
    if (dest_out !== 4'b0011 || pkt_active !== 1'b1) begin
      failures++;
      $display("FAIL head_after_reset: dest=%b active=%b expected 0011/1", dest_out, pkt_active);
    end
    drive(1'b1, 64'hB1, 1'b1, 2'd1, 2'd0, 1'b0);
    idle(1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_noc        = 1'b1;
    mon_en         = 1'b0;
    fire_pending   = 1'b0;
    axis_in_tvalid = 1'b0;
    axis_in_tdata  = '0;
    axis_in_tlast  = 1'b0;
    axis_in_tid    = '0;
    axis_in_tdest  = '0;
    credit_in      = 1'b0;
    m_credits      = DEPTH;
    m_ovf          = 1'b0;
    m_body         = 1'b0;
    m_dest         = '0;
    @(negedge clk_noc);
    test_reset();
    test_single_flit();
    test_credit_exhaust();
    test_body_dest();
    test_back_to_back();
    test_credit_ovf();
    test_reset_mid_packet();
    idle(1'b0);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d flits never sent, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
